// File: rtl/vga_pkg.sv
// Shared video-timing defaults, position width, FSM state type and the
// saturating single-axis step used by the sprite position controller.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 1920;
    localparam int V_ACTIVE_DEF = 1080;
    localparam int POS_W        = 11;
    localparam int CALC_W       = POS_W + 1;

    // Bit positions of the buttons inside the packed {U, D, L, R} vector
    localparam int BTN_R = 0;
    localparam int BTN_L = 1;
    localparam int BTN_D = 2;
    localparam int BTN_U = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        COMMIT = 2'd2
    } fsm_state_t;

    // One axis step: dec alone moves toward 0, inc alone toward lim, both or
    // neither hold. The extra bit keeps cur+step from wrapping before the clamp.
    function automatic logic [CALC_W-1:0] axis_next(
        input logic [CALC_W-1:0] cur,
        input logic              dec,
        input logic              inc,
        input logic [CALC_W-1:0] step,
        input logic [CALC_W-1:0] lim
    );
        axis_next = cur;
        if (dec && !inc) begin
            axis_next = (cur >= step) ? cur - step : '0;
        end else if (inc && !dec) begin
            axis_next = (cur + step > lim) ? lim : cur + step;
        end
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a consecutive-difference debouncer for
// one raw push-button.
module btn_debounce #(
    parameter int DB_CYCLES = 1485000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    // The counter only runs while the synchronized input disagrees with the
    // debounced level; the level flips on the DB_CYCLES-th such cycle in a row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sprite_pos_ctrl.sv
// Moves a sprite's top-left corner by STEP pixels per frame from four
// debounced buttons, clamped to the visible area.
module sprite_pos_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int OBJ_W     = 64,
    parameter int OBJ_H     = 64,
    parameter int STEP      = 4,
    parameter int DB_CYCLES = 1485000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btnU,
    input  logic             btnD,
    input  logic             btnL,
    input  logic             btnR,
    input  logic             frame_tick,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y,
    output logic             pos_upd,
    output fsm_state_t       state
);

    localparam logic [CALC_W-1:0] X_LIM  = CALC_W'(H_ACTIVE - OBJ_W);
    localparam logic [CALC_W-1:0] Y_LIM  = CALC_W'(V_ACTIVE - OBJ_H);
    localparam logic [CALC_W-1:0] STEP_C = CALC_W'(STEP);
    localparam logic [POS_W-1:0]  X_HOME = POS_W'((H_ACTIVE - OBJ_W) / 2);
    localparam logic [POS_W-1:0]  Y_HOME = POS_W'((V_ACTIVE - OBJ_H) / 2);

    logic [3:0]        btn_raw;
    logic [3:0]        btn_db;
    logic [3:0]        btn_lat;
    fsm_state_t        next_state;
    logic              latch_en;
    logic              load_en;
    logic [CALC_W-1:0] x_next;
    logic [CALC_W-1:0] y_next;

    assign btn_raw = {btnU, btnD, btnL, btnR};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk   (clk),
            .rst   (rst),
            .raw   (btn_raw[i]),
            .level (btn_db[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A tick seen outside IDLE is simply dropped.
    always_comb begin
        next_state = state;
        latch_en   = 1'b0;
        load_en    = 1'b0;
        case (state)
            IDLE: begin
                if (frame_tick) begin
                    next_state = CALC;
                    latch_en   = 1'b1;
                end
            end
            CALC: begin
                next_state = COMMIT;
                load_en    = 1'b1;
            end
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        x_next = axis_next({1'b0, pos_x}, btn_lat[BTN_L], btn_lat[BTN_R], STEP_C, X_LIM);
        y_next = axis_next({1'b0, pos_y}, btn_lat[BTN_U], btn_lat[BTN_D], STEP_C, Y_LIM);
    end

    // The new position is clocked on the CALC->COMMIT edge, so it and pos_upd
    // are presented during the COMMIT cycle, two cycles after the tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_x   <= X_HOME;
            pos_y   <= Y_HOME;
            pos_upd <= 1'b0;
            btn_lat <= '0;
        end else begin
            pos_upd <= 1'b0;
            if (latch_en) begin
                btn_lat <= btn_db;
            end
            if (load_en) begin
                pos_x   <= x_next[POS_W-1:0];
                pos_y   <= y_next[POS_W-1:0];
                pos_upd <= (x_next != {1'b0, pos_x}) || (y_next != {1'b0, pos_y});
            end
        end
    end

endmodule
